// File: rtl/signal_safety_monitor.sv
// signal_safety_monitor
//   Sits between the two-path intersection controller and the lamp drivers.
//   Every clk it checks the requested car/walk codes for path 0 (N/S) and
//   path 1 (E/W) for conflicting permissive indications and illegal codes.
//   In NORMAL, a clean sample is shown on the lamps one clk later. A
//   violating sample freezes the lamps. FILTER_CYC consecutive violations
//   latch FAULT, which shows flashing red and steady don't-walk. FAULT is
//   left only after FILTER_CYC clean samples plus an operator clear.
// Ports
//   clk, rstn                clock, synchronous active-low reset
//   car_in_0/1   [3:0]       {red, yellow, left arrow, green} request
//   walk_in_0/1  [1:0]       {walk, don't-walk} request
//   fault_clr                level request to leave FAULT
//   lamp_car_0/1 [3:0]       registered car lamp drive
//   lamp_walk_0/1[1:0]       registered walk lamp drive
//   fault                    high while in FAULT
//   fault_code   [2:0]       cause of current/last fault: 1 car/car,
//                            2 walk0/car1, 3 walk1/car0, 4 illegal code
//   fault_cnt    [7:0]       FAULT entries since reset, saturating
module signal_safety_monitor #(
  parameter int FILTER_CYC = 4,
  parameter int FLASH_HALF = 50_000_000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [3:0] car_in_0,
  input  logic [3:0] car_in_1,
  input  logic [1:0] walk_in_0,
  input  logic [1:0] walk_in_1,
  input  logic       fault_clr,
  output logic [3:0] lamp_car_0,
  output logic [3:0] lamp_car_1,
  output logic [1:0] lamp_walk_0,
  output logic [1:0] lamp_walk_1,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic [7:0] fault_cnt
);

  localparam int FW = $clog2(FILTER_CYC + 1);
  localparam int HW = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
  localparam logic [FW-1:0] FILT_MAX   = FW'(FILTER_CYC);
  localparam logic [FW-1:0] FILT_LAST  = FW'(FILTER_CYC - 1);
  localparam logic [HW-1:0] FLASH_LAST = HW'(FLASH_HALF - 1);
  localparam logic [3:0]    CAR_RED    = 4'b1000;
  localparam logic [1:0]    WALK_DONT  = 2'b01;

  typedef enum logic {NORMAL, FAULT} state_t;

  state_t        state, state_nxt;
  logic [FW-1:0] filt_cnt, clean_cnt;
  logic [HW-1:0] flash_cnt;
  logic          phase;
  logic [2:0]    cap_cause;

  logic       go0, go1, illegal, viol;
  logic [2:0] cause;
  logic       enter, leave;
  logic       flash_wrap, phase_nxt;
  logic [3:0] map_car_0, map_car_1;
  logic [1:0] map_walk_0, map_walk_1;

  // One-hot or all-zero: clearing the lowest set bit leaves nothing.
  function automatic logic ok4(input logic [3:0] v);
    return (v & (v - 4'd1)) == 4'd0;
  endfunction

  function automatic logic ok2(input logic [1:0] v);
    return v != 2'b11;
  endfunction

  // Violation classification; evaluated lowest-priority first so the lowest
  // code wins when several causes hold at once.
  always_comb begin
    go0     = car_in_0[2:0] != 3'd0;
    go1     = car_in_1[2:0] != 3'd0;
    illegal = !ok4(car_in_0) || !ok4(car_in_1) || !ok2(walk_in_0) || !ok2(walk_in_1);
    cause   = 3'd0;
    if (illegal)             cause = 3'd4;
    if (walk_in_1[1] && go0) cause = 3'd3;
    if (walk_in_0[1] && go1) cause = 3'd2;
    if (go0 && go1)          cause = 3'd1;
    viol = cause != 3'd0;
  end

  // Idle codes are displayed as red / don't-walk.
  always_comb begin
    map_car_0  = (car_in_0  == 4'd0) ? CAR_RED   : car_in_0;
    map_car_1  = (car_in_1  == 4'd0) ? CAR_RED   : car_in_1;
    map_walk_0 = (walk_in_0 == 2'd0) ? WALK_DONT : walk_in_0;
    map_walk_1 = (walk_in_1 == 2'd0) ? WALK_DONT : walk_in_1;
  end

  always_comb begin
    flash_wrap = flash_cnt == FLASH_LAST;
    phase_nxt  = phase ^ flash_wrap;
  end

  always_ff @(posedge clk) begin
    if (!rstn) state <= NORMAL;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    enter     = 1'b0;
    leave     = 1'b0;
    case (state)
      NORMAL: if (viol && filt_cnt == FILT_LAST) begin
        state_nxt = FAULT;
        enter     = 1'b1;
      end
      FAULT: if (fault_clr && clean_cnt == FILT_MAX) begin
        state_nxt = NORMAL;
        leave     = 1'b1;
      end
      default: state_nxt = NORMAL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      lamp_car_0  <= CAR_RED;
      lamp_car_1  <= CAR_RED;
      lamp_walk_0 <= WALK_DONT;
      lamp_walk_1 <= WALK_DONT;
      fault       <= 1'b0;
      fault_code  <= 3'd0;
      fault_cnt   <= 8'd0;
      filt_cnt    <= '0;
      clean_cnt   <= '0;
      flash_cnt   <= '0;
      phase       <= 1'b0;
      cap_cause   <= 3'd0;
    end else if (state == NORMAL) begin
      if (!viol) begin
        lamp_car_0  <= map_car_0;
        lamp_car_1  <= map_car_1;
        lamp_walk_0 <= map_walk_0;
        lamp_walk_1 <= map_walk_1;
        filt_cnt    <= '0;
      end else if (enter) begin
        fault       <= 1'b1;
        // With FILTER_CYC=1 the run start is this very sample.
        fault_code  <= (filt_cnt == '0) ? cause : cap_cause;
        if (fault_cnt != 8'hFF) fault_cnt <= fault_cnt + 8'd1;
        flash_cnt   <= '0;
        phase       <= 1'b1;
        lamp_car_0  <= CAR_RED;
        lamp_car_1  <= CAR_RED;
        lamp_walk_0 <= WALK_DONT;
        lamp_walk_1 <= WALK_DONT;
        filt_cnt    <= '0;
        clean_cnt   <= '0;
      end else begin
        // Lamps hold: never pass a conflicting request through.
        filt_cnt <= filt_cnt + FW'(1);
        if (filt_cnt == '0) cap_cause <= cause;
      end
    end else begin
      if (leave) begin
        fault      <= 1'b0;
        fault_code <= 3'd0;
        filt_cnt   <= '0;
        clean_cnt  <= '0;
        // The clean run refers to earlier samples; this one may still be bad.
        lamp_car_0  <= viol ? CAR_RED   : map_car_0;
        lamp_car_1  <= viol ? CAR_RED   : map_car_1;
        lamp_walk_0 <= viol ? WALK_DONT : map_walk_0;
        lamp_walk_1 <= viol ? WALK_DONT : map_walk_1;
      end else begin
        flash_cnt   <= flash_wrap ? '0 : flash_cnt + HW'(1);
        phase       <= phase_nxt;
        lamp_car_0  <= {phase_nxt, 3'b000};
        lamp_car_1  <= {phase_nxt, 3'b000};
        lamp_walk_0 <= WALK_DONT;
        lamp_walk_1 <= WALK_DONT;
        if (viol)                       clean_cnt <= '0;
        else if (clean_cnt != FILT_MAX) clean_cnt <= clean_cnt + FW'(1);
      end
    end
  end

endmodule

// File: tb/tb_signal_safety_monitor.sv
module tb_signal_safety_monitor;

  logic       clk = 1'b0;
  logic       rstn;
  logic [3:0] car_in_0, car_in_1;
  logic [1:0] walk_in_0, walk_in_1;
  logic       fault_clr;
  logic [3:0] lamp_car_0, lamp_car_1;
  logic [1:0] lamp_walk_0, lamp_walk_1;
  logic       fault;
  logic [2:0] fault_code;
  logic [7:0] fault_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  signal_safety_monitor #(.FILTER_CYC(4), .FLASH_HALF(8)) dut (
    .clk(clk), .rstn(rstn),
    .car_in_0(car_in_0), .car_in_1(car_in_1),
    .walk_in_0(walk_in_0), .walk_in_1(walk_in_1),
    .fault_clr(fault_clr),
    .lamp_car_0(lamp_car_0), .lamp_car_1(lamp_car_1),
    .lamp_walk_0(lamp_walk_0), .lamp_walk_1(lamp_walk_1),
    .fault(fault), .fault_code(fault_code), .fault_cnt(fault_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] c0, c1;
    logic [1:0] w0, w1;
    logic       clr;
    logic [3:0] ec0, ec1;
    logic [1:0] ew0, ew1;
    logic       ef;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] c0, input logic [3:0] c1,
                       input logic [1:0] w0, input logic [1:0] w1, input logic clr);
    car_in_0 = c0; car_in_1 = c1; walk_in_0 = w0; walk_in_1 = w1; fault_clr = clr;
  endtask

  // Inputs change after negedge, outputs are sampled at the following negedge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_lamps(input string nm, input logic [3:0] c0, input logic [3:0] c1,
                           input logic [1:0] w0, input logic [1:0] w1);
    chk({nm, ".car0"},  lamp_car_0,  c0);
    chk({nm, ".car1"},  lamp_car_1,  c1);
    chk({nm, ".walk0"}, lamp_walk_0, w0);
    chk({nm, ".walk1"}, lamp_walk_1, w1);
  endtask

  task automatic chk_stat(input string nm, input logic f, input logic [2:0] code,
                          input logic [7:0] cnt);
    chk({nm, ".fault"}, fault, f);
    chk({nm, ".code"},  fault_code, code);
    chk({nm, ".cnt"},   fault_cnt, cnt);
  endtask

  // Clean inputs with fault_clr held: counter reaches 4 after four clean
  // edges, so the fifth edge is the one that leaves FAULT.
  task automatic do_exit(input string nm, input logic [7:0] cnt);
    drive(4'b0001, 4'b1000, 2'b10, 2'b01, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      step();
      chk($sformatf("%s.hold%0d", nm, i), fault, 1'b1);
    end
    step();
    chk_stat({nm, ".exit"}, 1'b0, 3'd0, cnt);
    chk_lamps({nm, ".exit"}, 4'b0001, 4'b1000, 2'b10, 2'b01);
    drive(4'b0001, 4'b1000, 2'b10, 2'b01, 1'b0);
  endtask

  initial begin
    //          c0       c1       w0     w1    clr   ec0      ec1      ew0    ew1   ef
    tbl[0]  = '{4'b0001, 4'b1000, 2'b10, 2'b01, 1'b0, 4'b0001, 4'b1000, 2'b10, 2'b01, 1'b0};
    tbl[1]  = '{4'b1000, 4'b0010, 2'b01, 2'b00, 1'b0, 4'b1000, 4'b0010, 2'b01, 2'b01, 1'b0};
    tbl[2]  = '{4'b0001, 4'b0001, 2'b01, 2'b01, 1'b0, 4'b1000, 4'b0010, 2'b01, 2'b01, 1'b0};
    tbl[3]  = '{4'b0001, 4'b0001, 2'b01, 2'b01, 1'b0, 4'b1000, 4'b0010, 2'b01, 2'b01, 1'b0};
    tbl[4]  = '{4'b0001, 4'b0001, 2'b01, 2'b01, 1'b0, 4'b1000, 4'b0010, 2'b01, 2'b01, 1'b0};
    tbl[5]  = '{4'b1000, 4'b1000, 2'b10, 2'b10, 1'b0, 4'b1000, 4'b1000, 2'b10, 2'b10, 1'b0};
    tbl[6]  = '{4'b1000, 4'b0100, 2'b10, 2'b01, 1'b0, 4'b1000, 4'b1000, 2'b10, 2'b10, 1'b0};
    tbl[7]  = '{4'b1000, 4'b0100, 2'b10, 2'b01, 1'b0, 4'b1000, 4'b1000, 2'b10, 2'b10, 1'b0};
    tbl[8]  = '{4'b1000, 4'b0100, 2'b10, 2'b01, 1'b0, 4'b1000, 4'b1000, 2'b10, 2'b10, 1'b0};
    tbl[9]  = '{4'b0000, 4'b0000, 2'b00, 2'b00, 1'b1, 4'b1000, 4'b1000, 2'b01, 2'b01, 1'b0};
    tbl[10] = '{4'b0011, 4'b1000, 2'b01, 2'b01, 1'b0, 4'b1000, 4'b1000, 2'b01, 2'b01, 1'b0};
    tbl[11] = '{4'b0100, 4'b1000, 2'b01, 2'b10, 1'b0, 4'b1000, 4'b1000, 2'b01, 2'b01, 1'b0};
    tbl[12] = '{4'b0010, 4'b1000, 2'b00, 2'b01, 1'b0, 4'b0010, 4'b1000, 2'b01, 2'b01, 1'b0};
    tbl[13] = '{4'b1000, 4'b0001, 2'b01, 2'b00, 1'b0, 4'b1000, 4'b0001, 2'b01, 2'b01, 1'b0};

    // Reset with idle inputs.
    rstn = 1'b0;
    drive(4'b0000, 4'b0000, 2'b00, 2'b00, 1'b0);
    @(negedge clk);
    step();
    step();
    chk_lamps("reset", 4'b1000, 4'b1000, 2'b01, 2'b01);
    chk_stat("reset", 1'b0, 3'd0, 8'd0);
    rstn = 1'b1;

    // Pass-through, short violation runs, illegal codes, fault_clr in NORMAL.
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].c0, tbl[i].c1, tbl[i].w0, tbl[i].w1, tbl[i].clr);
      step();
      chk_lamps($sformatf("vec%0d", i), tbl[i].ec0, tbl[i].ec1, tbl[i].ew0, tbl[i].ew1);
      chk($sformatf("vec%0d.fault", i), fault, tbl[i].ef);
    end
    chk_stat("vec_end", 1'b0, 3'd0, 8'd0);

    // Car/car conflict held: fault on the 4th edge.
    drive(4'b0001, 4'b0001, 2'b01, 2'b01, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      step();
      chk($sformatf("conf.pre%0d", i), fault, 1'b0);
      chk_lamps($sformatf("conf.pre%0d", i), 4'b1000, 4'b0001, 2'b01, 2'b01);
    end
    step();
    chk_stat("conf.entry", 1'b1, 3'd1, 8'd1);
    chk_lamps("conf.entry", 4'b1000, 4'b1000, 2'b01, 2'b01);

    // Flash: red for 8 clk from entry, dark for the next 8, then red again.
    for (int k = 1; k <= 16; k++) begin
      step();
      chk_lamps($sformatf("flash%0d", k), ((k / 8) % 2 == 0) ? 4'b1000 : 4'b0000,
                ((k / 8) % 2 == 0) ? 4'b1000 : 4'b0000, 2'b01, 2'b01);
    end

    // fault_clr while the conflict persists is ignored.
    drive(4'b0001, 4'b0001, 2'b01, 2'b01, 1'b1);
    step();
    step();
    chk_stat("clr_viol", 1'b1, 3'd1, 8'd1);
    do_exit("exit1", 8'd1);

    // Conflict and illegal code together: lowest cause recorded.
    drive(4'b0001, 4'b0110, 2'b01, 2'b01, 1'b0);
    for (int i = 0; i < 4; i++) step();
    chk_stat("prio", 1'b1, 3'd1, 8'd2);
    do_exit("exit2", 8'd2);

    // The cause of the first sample of the run is kept.
    drive(4'b1000, 4'b1000, 2'b11, 2'b01, 1'b0);
    step();
    chk("run_start.fault", fault, 1'b0);
    drive(4'b0001, 4'b0001, 2'b01, 2'b01, 1'b0);
    for (int i = 0; i < 3; i++) step();
    chk_stat("run_start", 1'b1, 3'd4, 8'd3);

    // Reset mid-FAULT with violating inputs still applied.
    rstn = 1'b0;
    step();
    chk_lamps("midrst", 4'b1000, 4'b1000, 2'b01, 2'b01);
    chk_stat("midrst", 1'b0, 3'd0, 8'd0);
    rstn = 1'b1;
    drive(4'b0000, 4'b0000, 2'b00, 2'b00, 1'b0);
    step();
    chk_lamps("post_rst", 4'b1000, 4'b1000, 2'b01, 2'b01);
    chk_stat("post_rst", 1'b0, 3'd0, 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
